// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: eq/gt/lt/diff of two latched operands, scanned MSB first.
// Latency: start accepted at edge k -> valid pulse between edges k+WIDTH and k+WIDTH+1.
// Backpressure: ready=1 only in IDLE; start while busy is dropped, not queued.
//
// Ports: clk/rst_n (async active-low); start/a/b request; ready; valid (1-cycle
// pulse); eq/gt/lt/diff hold the last result until the next one is posted.
module serial_magnitude_comparator #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             diff
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             gt_i;
    logic             lt_i;
    logic             gt_n;
    logic             lt_n;
    logic             undecided;

    // Single compare cell: only the first differing bit pair (from the MSB)
    // may set a flag; once either flag is set both stay frozen.
    always_comb begin
        undecided = ~gt_i & ~lt_i;
        gt_n      = gt_i | (undecided &  sa[WIDTH-1] & ~sb[WIDTH-1]);
        lt_n      = lt_i | (undecided & ~sa[WIDTH-1] &  sb[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            cnt  <= '0;
            gt_i <= 1'b0;
            lt_i <= 1'b0;
            eq   <= 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
            diff <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        gt_i <= 1'b0;
                        lt_i <= 1'b0;
                        cnt  <= CW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    gt_i <= gt_n;
                    lt_i <= lt_n;
                    sa   <= {sa[WIDTH-2:0], 1'b0};
                    sb   <= {sb[WIDTH-2:0], 1'b0};
                    if (cnt == '0) begin
                        // Publish on the same edge that enters DONE, using the
                        // flag values that already include the LSB pair.
                        gt   <= gt_n;
                        lt   <= lt_n;
                        eq   <= ~(gt_n | lt_n);
                        diff <= gt_n | lt_n;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
